// File: rtl/bcd_stopwatch_if.sv
// Control and display bundle between the stopwatch and its driver/consumers.
// The tick and raw buttons flow into the stopwatch; the count and status LEDs flow out.
interface bcd_stopwatch_if #(
  parameter int DIGITS = 4
);
  logic                  tick;
  logic                  btn_start_stop;
  logic                  btn_clear;
  logic [4*DIGITS-1:0]   bcd;
  logic                  run;
  logic                  ovf;

  modport master (
    output tick, btn_start_stop, btn_clear,
    input  bcd, run, ovf
  );

  modport slave (
    input  tick, btn_start_stop, btn_clear,
    output bcd, run, ovf
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// Start/stop/clear stopwatch: debounced buttons, control FSM and a DIGITS-wide
// BCD counter that advances once per prescaler tick while running.
module bcd_stopwatch #(
  parameter int DIGITS         = 4,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             clk50m,
  input  logic             rst_n,
  bcd_stopwatch_if.slave   sw
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Bit 0 is start/stop, bit 1 is clear.
  logic [1:0] btn_raw;
  logic [1:0] press;
  assign btn_raw = {sw.btn_clear, sw.btn_start_stop};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          sync1_q, sync2_q;
    logic          stable_q, stable_dly_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        stable_q     <= 1'b0;
        stable_dly_q <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= btn_raw[gi];
        sync2_q      <= sync1_q;
        stable_dly_q <= stable_q;
        if (sw.tick) begin
          if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
              stable_q <= sync2_q;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
      end
    end

    // Rising edge of the accepted level only; releases are silent.
    assign press[gi] = stable_q & ~stable_dly_q;
  end

  state_t              state_q, state_d;
  logic                run_q;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_inc;
  logic                ovf_q, ovf_d;
  logic                clear_cnt;
  logic [DIGITS:0]     carry;

  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      ST_IDLE: if (press[0]) state_d = ST_RUN;
      ST_RUN:  if (press[0]) state_d = ST_STOP;
      ST_STOP: begin
        if (press[1]) begin
          state_d   = ST_IDLE;
          clear_cnt = 1'b1;
        end else if (press[0]) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] dig;
    assign dig             = bcd_q[4*gi +: 4];
    assign carry[gi+1]     = carry[gi] & (dig == 4'd9);
    assign bcd_inc[4*gi +: 4] = carry[gi] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
  end

  // Counting is gated by the current state, so the entry cycle into RUN never counts.
  always_comb begin
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    if (clear_cnt) begin
      bcd_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == ST_RUN && sw.tick) begin
      bcd_d = bcd_inc;
      if (carry[DIGITS]) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == ST_RUN);
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sw.bcd = bcd_q;
  assign sw.run = run_q;
  assign sw.ovf = ovf_q;
endmodule
